// File: rtl/mdu_pkg.sv
// mdu_pkg: Funct codes, FSM states and sign-fixup helper shared by the HI/LO multiply/divide unit
package mdu_pkg;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   // returns {product/quotient negate, remainder negate}; the remainder follows the dividend
   function automatic logic [1:0] fix_signs(input logic sgn, input logic a_msb, input logic b_msb);
      return {sgn & (a_msb ^ b_msb), sgn & a_msb};
   endfunction
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: radix-2 iteration registers (shift-add multiply, restoring divide) on magnitudes
module mdu_datapath
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               step,
   input  logic               div_op,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               is_div,
   output logic [2*WIDTH-1:0] acc,
   output logic [WIDTH-1:0]   sh,
   output logic               sh_last
);
   logic [2*WIDTH-1:0] mc;
   logic [WIDTH:0]     r_sh, diff;
   logic               ge;

   assign r_sh    = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
   assign diff    = r_sh - {1'b0, mc[WIDTH-1:0]};
   assign ge      = ~diff[WIDTH];
   assign sh_last = sh[WIDTH-1:1] == '0;

   // load magnitudes, then one multiply or divide iteration per step
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc    <= '0;
         mc     <= '0;
         sh     <= '0;
         is_div <= 1'b0;
      end else if (load) begin
         acc    <= '0;
         mc     <= {{WIDTH{1'b0}}, div_op ? y : x};
         sh     <= div_op ? x : y;
         is_div <= div_op;
      end else if (step && is_div) begin
         acc[2*WIDTH-1:WIDTH] <= ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
         sh                   <= {sh[WIDTH-2:0], ge};
      end else if (step) begin
         acc <= sh[0] ? acc + mc : acc;
         mc  <= mc << 1;
         sh  <= sh >> 1;
      end
   end
endmodule

// File: rtl/mdu_control.sv
// mdu_control: HI/LO group decode, iterative mult/div FSM and HI/LO registers; MDU_EARLY_OUT_EN enables multiply early-out
module mdu_control
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic               neg_q, neg_r, b_zero, sgn, is_md, accept, load, step, is_div, sh_last;
   logic [1:0]         signs;
   logic [WIDTH-1:0]   a_mag, b_mag, sh, quo_f, rem_f;
   logic [2*WIDTH-1:0] acc, prod_f;

   assign is_md   = funct[5:2] == FUNCT_MULT[5:2];
   assign sgn     = ~funct[0];
   assign a_mag   = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
   assign b_mag   = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;
   assign signs   = fix_signs(sgn, op_a[WIDTH-1], op_b[WIDTH-1]);
   assign accept  = state == IDLE && issue && !flush;
   assign busy    = state != IDLE;
   assign rd_data = funct == FUNCT_MFHI ? hi : funct == FUNCT_MFLO ? lo : '0;
   assign prod_f  = neg_q ? -acc : acc;
   assign quo_f   = b_zero ? '1 : neg_q ? -sh : sh;
   assign rem_f   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   mdu_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .step    (step),
      .div_op  (funct[1]),
      .x       (a_mag),
      .y       (b_mag),
      .is_div  (is_div),
      .acc     (acc),
      .sh      (sh),
      .sh_last (sh_last)
   );

   // next state: accept in IDLE, iterate in CALC until done (or multiplier exhausted), write back in FIX
   always_comb begin
      load    = accept && is_md;
      step    = state == CALC;
      state_n = state;
      case (state)
         IDLE:    state_n = load ? ((EARLY && !funct[1] && b_mag == '0) ? FIX : CALC) : IDLE;
         CALC:    state_n = flush ? IDLE :
                            (cnt == CNT_W'(WIDTH - 1) || (EARLY && !is_div && sh_last)) ? FIX : CALC;
         default: state_n = IDLE;
      endcase
   end

   // state, iteration counter, latched signs and the architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_n;
         cnt   <= load ? '0 : step ? cnt + CNT_W'(1) : cnt;
         if (load) begin
            {neg_q, neg_r} <= signs;
            b_zero         <= op_b == '0;
         end
         if (accept && funct == FUNCT_MTHI) hi <= op_a;
         if (accept && funct == FUNCT_MTLO) lo <= op_a;
         if (state == FIX && !flush) begin
            if (is_div) begin
               hi <= rem_f;
               lo <= quo_f;
            end else begin
               {hi, lo} <= prod_f;
            end
         end
      end
   end
endmodule

// File: tb/tb_mdu_control.sv
// tb_mdu_control: scoreboard bench for mdu_control against an arithmetic reference model
module tb_mdu_control;
   localparam int W = 32;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
   localparam logic [W-1:0] MINV = 32'h8000_0000;

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           lat;
   } exp_t;

   logic         clk = 1'b0, reset_n = 1'b0, issue = 1'b0, flush = 1'b0, busy;
   logic [5:0]   funct = 6'd0;
   logic [W-1:0] op_a = '0, op_b = '0, rd_data, hi, lo;
   logic [W-1:0] mhi = '0, mlo = '0;
   int           tests = 0, fails = 0;
   exp_t         sbq[$];

   mdu_control #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .issue   (issue),
      .funct   (funct),
      .op_a    (op_a),
      .op_b    (op_b),
      .flush   (flush),
      .busy    (busy),
      .rd_data (rd_data),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: plain signed/unsigned arithmetic plus the documented corner cases
   task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output int lat);
      longint      sa, sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = W + 1;
      rh  = '0;
      rl  = '0;
      if (f == F_MULT || f == F_MULTU) begin
         p = (f == F_MULT) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
         {rh, rl} = p;
`ifdef MDU_EARLY_OUT_EN
         begin
            logic [W-1:0] m;
            m   = (f == F_MULT && b[W-1]) ? -b : b;
            lat = 1;
            for (int i = 0; i < W; i++) if (m[i]) lat = i + 2;
         end
`endif
      end else if (b == '0) begin
         rl = '1;
         rh = a;
      end else if (f == F_DIV && a == MINV && b == '1) begin
         rl = MINV;
         rh = '0;
      end else if (f == F_DIV) begin
         rl = W'(sa / sb);
         rh = W'(sa % sb);
      end else begin
         rl = a / b;
         rh = a % b;
      end
   endtask

   // monitor: every busy fall retires one scoreboard entry
   int   mon_cnt = 0;
   logic mon_prev = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (busy === 1'b1) mon_cnt++;
      else begin
         if (mon_prev) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_empty: busy fell with no expected result");
            end else begin
               mon_e = sbq.pop_front();
               check({mon_e.name, "_hi"}, hi, mon_e.hi);
               check({mon_e.name, "_lo"}, lo, mon_e.lo);
               if (mon_e.lat >= 0) check({mon_e.name, "_latency"}, mon_cnt, mon_e.lat);
            end
         end
         mon_cnt = 0;
      end
      mon_prev = (busy === 1'b1);
   end

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
      if (busy !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL busy_timeout: busy=%b after 100 cycles, expected 0", busy);
      end
   endtask

   task automatic start_op(input string name, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      model(f, a, b, e.hi, e.lo, e.lat);
      e.name = name;
      @(negedge clk);
      funct = f;
      op_a  = a;
      op_b  = b;
      issue = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      issue = 1'b0;
      mhi   = e.hi;
      mlo   = e.lo;
   endtask

   task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      start_op(name, f, a, b);
      wait_idle();
   endtask

   task automatic mt(input logic [5:0] f, input logic [W-1:0] a);
      @(negedge clk);
      funct = f;
      op_a  = a;
      issue = 1'b1;
      @(negedge clk);
      issue = 1'b0;
      if (f == F_MTHI) mhi = a;
      else mlo = a;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return MINV;
         4:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] old_hi, old_lo;
      exp_t         e;
      repeat (3) @(negedge clk);
      funct = F_MFHI;
      #1;
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_busy", busy, 0);
      check("reset_rd", rd_data, 0);
      reset_n = 1'b1;

      mt(F_MTHI, 32'h1234_5678);
      check("mthi", hi, 32'h1234_5678);
      check("mthi_busy", busy, 0);
      mt(F_MTLO, 32'h9ABC_DEF0);
      check("mtlo", lo, 32'h9ABC_DEF0);
      funct = F_MFHI;
      #1 check("mfhi_rd", rd_data, 32'h1234_5678);
      funct = F_MFLO;
      #1 check("mflo_rd", rd_data, 32'h9ABC_DEF0);
      funct = 6'b100000;
      #1 check("other_rd", rd_data, 0);

      run_op("mult_m1x2", F_MULT, '1, 32'd2);
      check("mult_m1x2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("multu_m1x2", F_MULTU, '1, 32'd2);
      check("multu_m1x2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
      check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu_7_0", F_DIVU, 32'd7, 32'd0);
      check("divu_7_0_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      run_op("div_min_m1", F_DIV, MINV, '1);
      check("div_min_m1_const", {hi, lo}, {32'd0, MINV});
      run_op("div_m5_0", F_DIV, 32'hFFFF_FFFB, 32'd0);
      run_op("mult_5x3", F_MULT, 32'd5, 32'd3);
      check("mult_5x3_const", {hi, lo}, 64'd15);
      run_op("mult_x0", F_MULT, 32'h1234_5678, 32'd0);

      // mfhi while busy shows old HI, and a second issue while busy has no effect
      old_hi = mhi;
      start_op("busy_issue", F_MULT, 32'hFFFF_FF00, 32'h0001_0003);
      repeat (2) @(negedge clk);
      funct = F_MFHI;
      #1 check("mfhi_while_busy", rd_data, old_hi);
      @(negedge clk);
      funct = F_DIV;
      op_a  = 32'd99;
      op_b  = 32'd7;
      issue = 1'b1;
      @(negedge clk);
      funct = F_MTHI;
      @(negedge clk);
      issue = 1'b0;
      wait_idle();

      // flush mid-divide keeps HI/LO
      old_hi = mhi;
      old_lo = mlo;
      e      = '{"flush_div", old_hi, old_lo, -1};
      @(negedge clk);
      funct = F_DIV;
      op_a  = 32'd1000;
      op_b  = 32'd3;
      issue = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      issue = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", busy, 0);
      wait_idle();

      // flush together with issue in IDLE drops the issue
      @(negedge clk);
      funct = F_MTHI;
      op_a  = 32'hDEAD_BEEF;
      issue = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      funct = F_MULT;
      @(negedge clk);
      issue = 1'b0;
      flush = 1'b0;
      check("flush_issue_hi", hi, mhi);
      check("flush_issue_busy", busy, 0);

      // reset mid-multiply clears everything
      e = '{"reset_mid", '0, '0, -1};
      @(negedge clk);
      funct = F_MULT;
      op_a  = 32'd77;
      op_b  = 32'd55;
      issue = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      issue = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      funct = F_MFLO;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_hi", hi, 0);
      check("rst_mid_lo", lo, 0);
      check("rst_mid_rd", rd_data, 0);
      reset_n = 1'b1;
      mhi = '0;
      mlo = '0;

      for (int i = 0; i < 40; i++) begin
         logic [5:0] f;
         f = {4'b0110, 2'($urandom_range(0, 3))};
         run_op($sformatf("rand%0d_f%b", i, f[1:0]), f, pick(), pick());
      end

      repeat (2) @(negedge clk);
      check("sb_drain", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mdu_control.md
Name: mdu_control

Overview:
- Parametrised successor to the combinational ALU function decoder, covering the MIPS HI/LO group.
- Decodes R-type Funct codes for mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Runs an iterative radix-2 multiply/divide engine and owns the HI/LO registers.
- Sits beside the ALU in EX and drives a stall (busy) back to the hazard unit.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- issue  in  1  EX-stage instruction is R-type and valid this cycle.
- funct  in  6  instruction Funct field.
- op_a  in  WIDTH  rs value: dividend, multiplicand, or mthi/mtlo source.
- op_b  in  WIDTH  rt value: divisor or multiplier.
- flush  in  1  kill in-flight operation; HI/LO keep their old values.
- busy  out  1  engine active; hazard unit stalls any HI/LO-group instruction.
- rd_data  out  WIDTH  combinational: HI when funct=010000, LO when funct=010010, else 0.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Decode:
  - mult=011000, multu=011001, div=011010, divu=011011.
  - mfhi=010000, mthi=010001, mflo=010010, mtlo=010011.
  - Signed when funct[0]=0, same rule as the ALU Sign output.
  - Any other funct is ignored.
- Reset (reset_n=0 at a clk edge): state=IDLE; busy, hi, lo, counter and all datapath registers go to 0. Reset wins over every other input, including mid-operation.
- States are IDLE, CALC and FIX.
  - IDLE, issue & mult/div: latch |op_a| and |op_b| (raw values if unsigned), latch result signs, counter=0, go to CALC.
  - IDLE, issue & mthi/mtlo: write op_a to hi/lo on that edge; stay in IDLE.
  - CALC: one iteration per cycle.
    - Multiply: shift-add, one multiplier bit per cycle, LSB first.
    - Divide: restoring; shift remainder, trial-subtract, set quotient bit.
    - After WIDTH iterations go to FIX.
  - FIX: apply signs, write hi/lo, return to IDLE.
    - Multiply: {hi,lo} = 2*WIDTH-bit product, negated if sign(a)^sign(b).
    - Divide: lo = quotient, negated if signs differ; hi = remainder with the sign of the dividend.
- busy = (state != IDLE), registered.
- Latency: accepted at edge E; busy high from E for WIDTH+1 cycles; hi/lo hold the result after edge E+WIDTH+1.
- issue while busy: ignored. Stalling the pipeline is the hazard unit's job; the bench checks there is no effect.
- mfhi/mflo while busy: rd_data shows the old hi/lo. The consumer must stall on busy.
- Divide by zero (op_b=0), no trap: lo = all ones; hi = op_a unmodified.
- Signed overflow, most-negative / -1: lo = most-negative; hi = 0.
- Unsigned multiply: full 2*WIDTH product, no truncation.
- flush:
  - In CALC or FIX: go to IDLE next edge, no hi/lo write.
  - flush together with issue in IDLE: the issue is dropped.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in multiply CALC, when the remaining multiplier bits are all zero, jump straight to FIX. Latency becomes (index of highest set bit of |op_b| + 2) cycles; minimum 1 cycle when the multiplier is 0.
- Undefined: fixed WIDTH+1 cycle latency for every multiply.
- Divide latency is fixed in both builds.

Decomposition:
- Shared package mdu_pkg:
  - FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO constants.
  - State enum IDLE/CALC/FIX.
  - Sign-fixup helper function.
- One natural sub-module: mdu_datapath, holding the shift/add/subtract iteration registers and step logic.
- mdu_control keeps the FSM, counter, decode and hi/lo.

Test Plan:
- Reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 → hi/lo equal those values the next cycle. mfhi shows rd_data=0x12345678 combinationally. busy stays 0.
- mult op_a=0xFFFFFFFF(-1), op_b=0x00000002 → busy high exactly 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat as multu → hi=0x00000001, lo=0xFFFFFFFE.
- div op_a=-7 (0xFFFFFFF9), op_b=2 → lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). divu 7/0 → lo=0xFFFFFFFF, hi=7.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Mid-operation events:
  - Issue div, assert flush at cycle 10 → busy drops next edge; hi/lo keep their prior values.
  - Issue mult, drop reset_n at cycle 5 → all outputs 0 after that edge.
  - A second issue while busy → no effect on the result.
- With MDU_EARLY_OUT_EN: mult 5×3 → busy for 3 cycles, lo=15, hi=0. Without the macro: 33 cycles, same result.
